// File: rtl/mips_mc_control_pkg.sv
// Shared constants for the multi-cycle MIPS control FSM: state codes, opcodes,
// mux selects and the packed datapath control word.
package mips_mc_pkg;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWB  = 4'd5,
        S_MEMWR  = 4'd6,
        S_EXEC   = 4'd7,
        S_RWB    = 4'd8,
        S_BRANCH = 4'd9,
        S_JUMP   = 4'd10,
        S_ADDIEX = 4'd11,
        S_ADDIWB = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam logic [1:0] SRCB_REG   = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       ir_write;
        logic       alu_src_a;
        logic       reg_write;
        logic       reg_dst;
        logic [1:0] pc_source;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
    } ctrl_t;

endpackage

// File: rtl/mips_mc_control_if.sv
// Control bundle between the multi-cycle controller (master) and the datapath (slave).
interface mips_mc_control_if;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       PCWrite;
    logic       PCWriteCond;
    logic       IorD;
    logic       MemRead;
    logic       MemWrite;
    logic       MemtoReg;
    logic       IRWrite;
    logic       ALUSrcA;
    logic       RegWrite;
    logic       RegDst;
    logic [1:0] PCSource;
    logic [1:0] ALUSrcB;
    logic [1:0] ALUOp;
    logic       illegal_op;
    logic [3:0] state;

    modport master (
        input  opcode, mem_ready,
        output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
               ALUSrcA, RegWrite, RegDst, PCSource, ALUSrcB, ALUOp, illegal_op, state
    );

    modport slave (
        output opcode, mem_ready,
        input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
               ALUSrcA, RegWrite, RegDst, PCSource, ALUSrcB, ALUOp, illegal_op, state
    );
endinterface

// File: rtl/mips_mc_control_outdec.sv
// Combinational state -> control word decode (Moore, except FETCH IRWrite/PCWrite
// which follow mem_ready). ADDI states decoded only with MC_ADDI_EN.
module mips_mc_outdec
    import mips_mc_pkg::*;
(
    input  state_t i_state,
    input  logic   i_mem_ready,
    output ctrl_t  o_ctrl
);

    always_comb begin
        o_ctrl = '0;
        case (i_state)
            S_FETCH: begin
                o_ctrl.mem_read  = 1'b1;
                o_ctrl.alu_src_b = SRCB_FOUR;
                o_ctrl.alu_op    = ALUOP_ADD;
                o_ctrl.pc_source = PCSRC_ALU;
                // Only commit the fetched word and PC+4 when memory delivers.
                o_ctrl.ir_write  = i_mem_ready;
                o_ctrl.pc_write  = i_mem_ready;
            end
            S_DECODE: begin
                o_ctrl.alu_src_b = SRCB_IMMSH;
                o_ctrl.alu_op    = ALUOP_ADD;
            end
            S_MEMADR: begin
                o_ctrl.alu_src_a = 1'b1;
                o_ctrl.alu_src_b = SRCB_IMM;
                o_ctrl.alu_op    = ALUOP_ADD;
            end
            S_MEMRD: begin
                o_ctrl.mem_read = 1'b1;
                o_ctrl.iord     = 1'b1;
            end
            S_MEMWB: begin
                o_ctrl.reg_write  = 1'b1;
                o_ctrl.mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                o_ctrl.mem_write = 1'b1;
                o_ctrl.iord      = 1'b1;
            end
            S_EXEC: begin
                o_ctrl.alu_src_a = 1'b1;
                o_ctrl.alu_src_b = SRCB_REG;
                o_ctrl.alu_op    = ALUOP_FUNCT;
            end
            S_RWB: begin
                o_ctrl.reg_write = 1'b1;
                o_ctrl.reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                o_ctrl.alu_src_a     = 1'b1;
                o_ctrl.alu_src_b     = SRCB_REG;
                o_ctrl.alu_op        = ALUOP_SUB;
                o_ctrl.pc_write_cond = 1'b1;
                o_ctrl.pc_source     = PCSRC_ALUOUT;
            end
            S_JUMP: begin
                o_ctrl.pc_write  = 1'b1;
                o_ctrl.pc_source = PCSRC_JUMP;
            end
`ifdef MC_ADDI_EN
            S_ADDIEX: begin
                o_ctrl.alu_src_a = 1'b1;
                o_ctrl.alu_src_b = SRCB_IMM;
                o_ctrl.alu_op    = ALUOP_ADD;
            end
            S_ADDIWB: begin
                o_ctrl.reg_write = 1'b1;
            end
`endif
            default: ;
        endcase
    end

endmodule

// File: rtl/mips_mc_control.sv
// Multi-cycle MIPS main control: state register + next-state, stalls on mem_ready
// in FETCH/MEMRD/MEMWR. Optional addi path enabled by `MC_ADDI_EN.
module mips_mc_control
    import mips_mc_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    mips_mc_control_if.master bus
);

    state_t r_state;
    state_t w_next;
    logic   w_illegal;
    ctrl_t  w_ctrl;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        w_illegal = 1'b0;
        case (r_state)
            S_IDLE:   w_next = S_FETCH;
            S_FETCH:  if (bus.mem_ready) w_next = S_DECODE;
            S_DECODE: begin
                case (bus.opcode)
                    OP_RTYPE:     w_next = S_EXEC;
                    OP_LW, OP_SW: w_next = S_MEMADR;
                    OP_BEQ:       w_next = S_BRANCH;
                    OP_J:         w_next = S_JUMP;
`ifdef MC_ADDI_EN
                    OP_ADDI:      w_next = S_ADDIEX;
`else
                    OP_ADDI: begin
                        w_next    = S_FETCH;
                        w_illegal = 1'b1;
                    end
`endif
                    default: begin
                        w_next    = S_FETCH;
                        w_illegal = 1'b1;
                    end
                endcase
            end
            // IR is frozen outside FETCH, so the opcode is still valid here.
            S_MEMADR: w_next = (bus.opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  if (bus.mem_ready) w_next = S_MEMWB;
            S_MEMWB:  w_next = S_FETCH;
            S_MEMWR:  if (bus.mem_ready) w_next = S_FETCH;
            S_EXEC:   w_next = S_RWB;
            S_RWB:    w_next = S_FETCH;
            S_BRANCH: w_next = S_FETCH;
            S_JUMP:   w_next = S_FETCH;
`ifdef MC_ADDI_EN
            S_ADDIEX: w_next = S_ADDIWB;
            S_ADDIWB: w_next = S_FETCH;
`endif
            default:  w_next = S_IDLE;
        endcase
    end

    mips_mc_outdec u_outdec (
        .i_state     (r_state),
        .i_mem_ready (bus.mem_ready),
        .o_ctrl      (w_ctrl)
    );

    assign bus.PCWrite     = w_ctrl.pc_write;
    assign bus.PCWriteCond = w_ctrl.pc_write_cond;
    assign bus.IorD        = w_ctrl.iord;
    assign bus.MemRead     = w_ctrl.mem_read;
    assign bus.MemWrite    = w_ctrl.mem_write;
    assign bus.MemtoReg    = w_ctrl.mem_to_reg;
    assign bus.IRWrite     = w_ctrl.ir_write;
    assign bus.ALUSrcA     = w_ctrl.alu_src_a;
    assign bus.RegWrite    = w_ctrl.reg_write;
    assign bus.RegDst      = w_ctrl.reg_dst;
    assign bus.PCSource    = w_ctrl.pc_source;
    assign bus.ALUSrcB     = w_ctrl.alu_src_b;
    assign bus.ALUOp       = w_ctrl.alu_op;
    assign bus.illegal_op  = w_illegal;
    assign bus.state       = r_state;

endmodule

// File: tb/tb_mips_mc_control.sv
// Table-driven bench for mips_mc_control with a queue scoreboard of expected
// state + control word per cycle, plus hand sequences for asynchronous reset.
module tb_mips_mc_control;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    mips_mc_control_if dif ();

    mips_mc_control u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (dif)
    );

    typedef struct {
        bit [5:0] op;
        bit       mr;
        int       st;
    } vec_t;

    typedef struct {
        int          st;
        logic [16:0] ctl;
        string       tag;
    } exp_t;

    localparam bit [5:0] R  = 6'b000000;
    localparam bit [5:0] LW = 6'b100011;
    localparam bit [5:0] SW = 6'b101011;
    localparam bit [5:0] BQ = 6'b000100;
    localparam bit [5:0] JP = 6'b000010;
    localparam bit [5:0] AD = 6'b001000;
    localparam bit [5:0] IL = 6'b111111;

    vec_t vecs[$];
    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    // Reference outputs straight from the per-state table:
    // {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,MemtoReg,IRWrite,ALUSrcA,
    //  RegWrite,RegDst,PCSource,ALUSrcB,ALUOp,illegal_op}
    function automatic logic [16:0] exp_out(int st, bit mr, bit [5:0] op);
        bit pcw = 0, pcwc = 0, iord = 0, mrd = 0, mwr = 0, m2r = 0, irw = 0;
        bit asa = 0, rw = 0, rd = 0, ill = 0, legal = 0;
        bit [1:0] pcs = 0, asb = 0, aop = 0;
        case (st)
            1:  begin mrd = 1; asb = 2'b01; irw = mr; pcw = mr; end
            2:  begin
                    asb = 2'b11;
                    legal = (op == R) || (op == LW) || (op == SW) || (op == BQ) || (op == JP);
`ifdef MC_ADDI_EN
                    if (op == AD) legal = 1;
`endif
                    ill = !legal;
                end
            3:  begin asa = 1; asb = 2'b10; end
            4:  begin mrd = 1; iord = 1; end
            5:  begin rw = 1; m2r = 1; end
            6:  begin mwr = 1; iord = 1; end
            7:  begin asa = 1; aop = 2'b10; end
            8:  begin rw = 1; rd = 1; end
            9:  begin asa = 1; aop = 2'b01; pcwc = 1; pcs = 2'b01; end
            10: begin pcw = 1; pcs = 2'b10; end
            11: begin asa = 1; asb = 2'b10; end
            12: begin rw = 1; end
            default: ;
        endcase
        return {pcw, pcwc, iord, mrd, mwr, m2r, irw, asa, rw, rd, pcs, asb, aop, ill};
    endfunction

    function automatic logic [16:0] got_ctl();
        return {dif.PCWrite, dif.PCWriteCond, dif.IorD, dif.MemRead, dif.MemWrite,
                dif.MemtoReg, dif.IRWrite, dif.ALUSrcA, dif.RegWrite, dif.RegDst,
                dif.PCSource, dif.ALUSrcB, dif.ALUOp, dif.illegal_op};
    endfunction

    function automatic void add(bit [5:0] op, bit mr, int st);
        vecs.push_back('{op, mr, st});
    endfunction

    task automatic check_now();
        exp_t        e;
        logic [16:0] g;
        e = exp_q.pop_front();
        g = got_ctl();
        n_vec++;
        if (dif.state !== e.st[3:0] || g !== e.ctl) begin
            n_err++;
            $display("FAIL %s: got state=%0d ctl=%05h, expected state=%0d ctl=%05h",
                     e.tag, dif.state, g, e.st, e.ctl);
        end
    endtask

    // Called at posedge+1: drive, record expectation, sample at negedge.
    task automatic step(input bit [5:0] op, input bit mr, input int st, input string tag);
        dif.opcode    = op;
        dif.mem_ready = mr;
        exp_q.push_back('{st, exp_out(st, mr, op), tag});
        @(negedge clk);
        check_now();
        @(posedge clk);
        #1;
    endtask

    initial begin
        add(R, 1, 0);
        add(R, 1, 1); add(R, 1, 2); add(R, 1, 7); add(R, 1, 8);
        add(LW, 0, 1); add(LW, 0, 1); add(LW, 1, 1); add(LW, 1, 2); add(LW, 1, 3);
        add(LW, 0, 4); add(LW, 0, 4); add(LW, 0, 4); add(LW, 1, 4); add(LW, 1, 5);
        add(SW, 1, 1); add(SW, 1, 2); add(SW, 1, 3); add(SW, 0, 6); add(SW, 1, 6);
        add(BQ, 1, 1); add(BQ, 1, 2); add(BQ, 1, 9);
        add(JP, 1, 1); add(JP, 0, 2); add(JP, 0, 10);
        add(R, 1, 1); add(R, 0, 2); add(R, 0, 7); add(R, 0, 8);
        add(IL, 1, 1); add(IL, 1, 2);
        add(AD, 1, 1); add(AD, 1, 2);
`ifdef MC_ADDI_EN
        add(AD, 0, 11); add(AD, 0, 12);
`endif
        add(R, 1, 1);

        rst_n         = 1'b0;
        dif.opcode    = '0;
        dif.mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        step(R, 1, 0, "reset_hold");
        rst_n = 1'b1;

        foreach (vecs[i])
            step(vecs[i].op, vecs[i].mr, vecs[i].st, $sformatf("vec%0d", i));

        // Reset pulled mid-instruction while stalled in MEMRD.
        step(LW, 1, 2, "rst_decode");
        step(LW, 1, 3, "rst_memadr");
        step(LW, 0, 4, "rst_memrd");
        #2;
        rst_n = 1'b0;
        #1;
        exp_q.push_back('{0, exp_out(0, 0, LW), "rst_async"});
        check_now();
        @(posedge clk);
        #1;
        step(LW, 1, 0, "rst_held");
        rst_n = 1'b1;
        step(LW, 1, 0, "rst_idle");
        step(LW, 1, 1, "rst_fetch");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
